// File: rtl/dm_writeback_cache_if.sv
// Bus bundle for one dm_writeback_cache instance.
//
// Carries the CPU-side request/response port (mem_*) and the line-granular
// physical memory port (pmem_*).
//   slave  : the cache. It is the responder for mem_* and the requester on pmem_*.
//   master : the environment. It is the CPU on mem_* and the memory on pmem_*.
interface dm_writeback_cache_if #(
    parameter int S_OFFSET = 5
);
    localparam int LINE_W = 8 << S_OFFSET;

    logic              mem_read;
    logic              mem_write;
    logic [3:0]        mem_byte_enable;
    logic [31:0]       mem_address;
    logic [31:0]       mem_wdata;
    logic              mem_resp;
    logic [31:0]       mem_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dm_writeback_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache.
//
// Hits complete combinationally in the cycle the request is presented.
// A miss optionally writes back the dirty victim line, then fills the line
// from physical memory. The original request then hits one cycle later.
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset. It clears the valid and dirty bits
//           and the miss state. The tag and data arrays keep their contents.
//   bus   : dm_writeback_cache_if.slave
//           mem_*  : CPU request (read/write/byte enable/address/wdata) in,
//                    and resp/rdata out
//           pmem_* : 256-bit line read/write port to physical memory
module dm_writeback_cache #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3
) (
    input logic                 clk,
    input logic                 reset,
    dm_writeback_cache_if.slave bus
);
    localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
    localparam int SETS   = 1 << S_INDEX;
    localparam int LINE_W = 8 << S_OFFSET;
    localparam int S_WORD = S_OFFSET - 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state;
    logic   fill_req;
    logic   wb_req;

    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;
    logic [S_TAG-1:0]  tag_arr  [SETS];
    logic [LINE_W-1:0] data_arr [SETS];

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] idx;
    logic [S_WORD-1:0]  word;
    logic [S_WORD+4:0]  word_bit;
    logic               req;
    logic               hit;
    logic               write_hit;
    logic               fill_done;
    logic [LINE_W-1:0]  line;
    logic [31:0]        cur_word;
    logic [LINE_W-1:0]  merged_line;

    // Byte-lane merge of CPU write data into the stored word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return res;
    endfunction

    assign req_tag  = bus.mem_address[31 -: S_TAG];
    assign idx      = bus.mem_address[S_OFFSET +: S_INDEX];
    assign word     = bus.mem_address[2 +: S_WORD];
    assign word_bit = {word, 5'b00000};

    assign req       = bus.mem_read | bus.mem_write;
    assign hit       = (state == IDLE) && valid[idx] && (tag_arr[idx] == req_tag) && req;
    // A simultaneous read and write is treated as a write.
    // The read data still shows the pre-write word, because the array read is combinational.
    assign write_hit = hit && bus.mem_write;
    assign fill_done = (state == ALLOCATE) && bus.pmem_resp;

    assign line     = data_arr[idx];
    assign cur_word = line[word_bit +: 32];

    always_comb begin
        merged_line = line;
        merged_line[word_bit +: 32] = merge_bytes(cur_word, bus.mem_wdata, bus.mem_byte_enable);
    end

    assign bus.mem_resp   = hit;
    assign bus.mem_rdata  = hit ? cur_word : 32'h0;
    assign bus.pmem_read  = fill_req;
    assign bus.pmem_write = wb_req;
    assign bus.pmem_wdata = line;

    // The writeback address comes from the stored victim tag.
    // The fill address comes from the request, which is held stable across the miss.
    always_comb begin
        if (state == WRITEBACK) begin
            bus.pmem_address = {tag_arr[idx], idx, {S_OFFSET{1'b0}}};
        end else begin
            bus.pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
        end
    end

    // Control: state, pmem strobes, valid/dirty bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fill_req <= 1'b0;
            wb_req   <= 1'b0;
            valid    <= '0;
            dirty    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (bus.mem_write) begin
                            dirty[idx] <= dirty[idx] | (|bus.mem_byte_enable);
                        end
                    end else if (req) begin
                        if (valid[idx] && dirty[idx]) begin
                            state  <= WRITEBACK;
                            wb_req <= 1'b1;
                        end else begin
                            state    <= ALLOCATE;
                            fill_req <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty[idx] <= 1'b0;
                        state      <= ALLOCATE;
                        wb_req     <= 1'b0;
                        fill_req   <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        state      <= IDLE;
                        fill_req   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    fill_req <= 1'b0;
                    wb_req   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: tag and line data, deliberately not reset.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[idx] <= bus.pmem_rdata;
            tag_arr[idx]  <= req_tag;
        end else if (write_hit) begin
            data_arr[idx] <= merged_line;
        end
    end
endmodule

// File: tb/tb_dm_writeback_cache.sv
// Self-checking bench for dm_writeback_cache.
//
// The cache contents are modelled as word arrays. Every cycle the expected
// outputs are derived from that model and compared with the DUT.
// Directed CPU transactions add literal expectations on top of the model checks.
// The memory side answers each line request after a fixed number of cycles.
module tb_dm_writeback_cache;
    localparam int MEM_LAT = 3;

    logic clk = 1'b0;
    logic reset;

    dm_writeback_cache_if bus ();

    dm_writeback_cache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Fill pattern: word i of the line at address a is 0x1000 + a[15:12]*0x1000 + i.
    function automatic logic [255:0] build_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = 32'h1000 + {16'h0, a[15:12], 12'h000} + 32'(i);
        end
        return l;
    endfunction

    // ---------------- memory responder ----------------
    initial begin : memory
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end else if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
                cnt++;
                if (cnt >= MEM_LAT) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = build_line(bus.pmem_address);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [23:0] m_tag   [8];
    logic [31:0] m_data  [8][8];
    int          phase;      // 0: no miss outstanding, 1: victim being written, 2: line being fetched
    bit          model_on = 0;

    initial begin : model
        logic [31:0]  a;
        logic [2:0]   idx;
        logic [2:0]   w;
        logic [23:0]  tg;
        logic         req;
        logic         hit;
        logic [255:0] exp_line;
        logic [31:0]  old;
        phase = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                model_on = 1;
                phase    = 0;
                for (int i = 0; i < 8; i++) begin
                    m_valid[i] = 0;
                    m_dirty[i] = 0;
                end
                continue;
            end
            if (!model_on) continue;
            a   = bus.mem_address;
            idx = a[7:5];
            w   = a[4:2];
            tg  = a[31:8];
            req = bus.mem_read | bus.mem_write;
            hit = (phase == 0) && req && m_valid[idx] && (m_tag[idx] == tg);

            check("mem_resp", 256'(bus.mem_resp), 256'(hit));
            check("mem_rdata", 256'(bus.mem_rdata), 256'(hit ? m_data[idx][w] : 32'h0));
            check("pmem_read", 256'(bus.pmem_read), 256'(phase == 2));
            check("pmem_write", 256'(bus.pmem_write), 256'(phase == 1));
            if (phase == 1) begin
                for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = m_data[idx][i];
                check("wb_addr", 256'(bus.pmem_address), 256'({m_tag[idx], idx, 5'b0}));
                check("wb_data", bus.pmem_wdata, exp_line);
            end
            if (phase == 2) begin
                check("fill_addr", 256'(bus.pmem_address), 256'({tg, idx, 5'b0}));
            end

            // Advance the model to reflect the coming clock edge.
            if (phase == 0) begin
                if (hit && bus.mem_write) begin
                    old = m_data[idx][w];
                    for (int b = 0; b < 4; b++) begin
                        if (bus.mem_byte_enable[b]) old[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                    end
                    m_data[idx][w] = old;
                    if (bus.mem_byte_enable != 4'h0) m_dirty[idx] = 1;
                end else if (req && !hit) begin
                    phase = (m_valid[idx] && m_dirty[idx]) ? 1 : 2;
                end
            end else if (phase == 1) begin
                if (bus.pmem_resp) begin
                    m_dirty[idx] = 0;
                    phase = 2;
                end
            end else begin
                if (bus.pmem_resp) begin
                    for (int i = 0; i < 8; i++) m_data[idx][i] = bus.pmem_rdata[i*32 +: 32];
                    m_valid[idx] = 1;
                    m_dirty[idx] = 0;
                    m_tag[idx]   = tg;
                    phase = 0;
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    logic [31:0] got_rdata;
    int          cycles;
    int          presp_cycle;
    bit          saw_pr;
    bit          saw_pw;
    bit          saw_both;
    logic [31:0] pr_addr;
    logic [31:0] pw_addr;
    logic [31:0] pw_word2;

    // Called at posedge+#1. Holds the request until mem_resp, then drops it after that edge.
    task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        bit done;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        saw_pr = 0; saw_pw = 0; saw_both = 0;
        pr_addr = 0; pw_addr = 0; pw_word2 = 0;
        cycles = 0; presp_cycle = -10; got_rdata = 0;
        done = 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (bus.pmem_read === 1'b1 && !saw_pr) begin
                saw_pr  = 1;
                pr_addr = bus.pmem_address;
            end
            if (bus.pmem_write === 1'b1 && !saw_pw) begin
                saw_pw   = 1;
                pw_addr  = bus.pmem_address;
                pw_word2 = bus.pmem_wdata[95:64];
            end
            if (bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1) saw_both = 1;
            if (bus.pmem_resp) presp_cycle = cycles;
            if (bus.mem_resp === 1'b1) begin
                done      = 1;
                got_rdata = bus.mem_rdata;
            end
        end
        if (!done) begin
            failures++;
            $display("FAIL timeout addr=%h actual=no_resp required=resp", addr);
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        int n;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 4'h0;
        bus.mem_address     = 32'h0;
        bus.mem_wdata       = 32'h0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp", 256'(bus.mem_resp), 256'(1'b0));
        check("rst_pmem_read", 256'(bus.pmem_read), 256'(1'b0));
        check("rst_pmem_write", 256'(bus.pmem_write), 256'(1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cold read miss on 0x104.
        cpu_req(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
        check("miss_rdata", 256'(got_rdata), 256'(32'h0000_1001));
        check("miss_fill_addr", 256'(pr_addr), 256'(32'h0000_0100));
        check("miss_no_wb", 256'(saw_pw), 256'(1'b0));
        check("miss_resp_lag", 256'(cycles), 256'(presp_cycle + 1));

        // Back-to-back read hits.
        cpu_req(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0);
        check("b2b0_rdata", 256'(got_rdata), 256'(32'h0000_1000));
        check("b2b0_cycles", 256'(cycles), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_011C, 4'h0, 32'h0);
        check("b2b1_rdata", 256'(got_rdata), 256'(32'h0000_1007));
        check("b2b1_cycles", 256'(cycles), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_0108, 4'h0, 32'h0);
        check("b2b2_rdata", 256'(got_rdata), 256'(32'h0000_1002));
        check("b2b2_cycles", 256'(cycles), 256'(1));

        // Masked write hit: bytes 0 and 2 replaced in 0x00001002.
        cpu_req(1'b0, 1'b1, 32'h0000_0108, 4'b0101, 32'hAABB_CCDD);
        check("wr_cycles", 256'(cycles), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_0108, 4'h0, 32'h0);
        check("wr_readback", 256'(got_rdata), 256'(32'h00BB_10DD));

        // Conflict miss with the line dirty: writeback, then fill.
        cpu_req(1'b1, 1'b0, 32'h0000_1108, 4'h0, 32'h0);
        check("evict_wb_seen", 256'(saw_pw), 256'(1'b1));
        check("evict_wb_addr", 256'(pw_addr), 256'(32'h0000_0100));
        check("evict_wb_word2", 256'(pw_word2), 256'(32'h00BB_10DD));
        check("evict_fill_addr", 256'(pr_addr), 256'(32'h0000_1100));
        check("evict_no_overlap", 256'(saw_both), 256'(1'b0));
        check("evict_rdata", 256'(got_rdata), 256'(32'h0000_2002));

        // Reset while the fill is outstanding.
        bus.mem_read    = 1'b1;
        bus.mem_address = 32'h0000_2104;
        n = 0;
        while (bus.pmem_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_alloc_started", 256'(bus.pmem_read), 256'(1'b1));
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_alloc_drop", 256'(bus.pmem_read), 256'(1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_req(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
        check("rst_remiss", 256'(saw_pr), 256'(1'b1));
        check("rst_remiss_addr", 256'(pr_addr), 256'(32'h0000_0100));
        check("rst_remiss_rdata", 256'(got_rdata), 256'(32'h0000_1001));

        // Zero-mask write on a clean hit leaves data and dirty untouched.
        cpu_req(1'b0, 1'b1, 32'h0000_0104, 4'h0, 32'hFFFF_FFFF);
        check("zmask_cycles", 256'(cycles), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
        check("zmask_data", 256'(got_rdata), 256'(32'h0000_1001));
        cpu_req(1'b1, 1'b0, 32'h0000_1104, 4'h0, 32'h0);
        check("zmask_no_wb", 256'(saw_pw), 256'(1'b0));
        check("zmask_evict_rdata", 256'(got_rdata), 256'(32'h0000_2001));

        // Read and write together: acts as a write, returns the old word.
        cpu_req(1'b1, 1'b1, 32'h0000_1100, 4'hF, 32'h1234_5678);
        check("rw_old_word", 256'(got_rdata), 256'(32'h0000_2000));
        check("rw_cycles", 256'(cycles), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_1100, 4'h0, 32'h0);
        check("rw_new_word", 256'(got_rdata), 256'(32'h1234_5678));

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
